enigma_stream_decoder: RTL and testbench

//  Byte-serial receive-side decoder for the Enigma cipher path: accepts ciphertext bytes
//  on a valid/ready stream, buffers one block and decrypts each byte on acceptance with a

---
 rtl/enigma_stream_decoder_if.sv | 24 ++
 rtl/enigma_stream_decoder.sv | 145 ++++++++++++++
 tb/tb_enigma_stream_decoder.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_stream_decoder_if.sv
// Byte stream bundle for the Enigma receive decoder.
// The ciphertext input stream and the plaintext output stream each carry
// valid/ready, data and last. The decoder takes the slave modport; the
// side that feeds ciphertext and consumes plaintext takes the master modport.
interface enigma_stream_decoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/enigma_stream_decoder.sv
// Enigma receive-side block decoder.
// Ciphertext bytes are decrypted as they are accepted, using a stepping
// Caesar rotor keyed by key_i. The decrypted bytes go into a block buffer.
// The whole block is then replayed in order on the output stream.
// Filling and draining never overlap.
//
// state | meaning
// FILL  | accepting ciphertext, decrypting into the buffer
// DRAIN | replaying the buffered plaintext block, input stalled
module enigma_stream_decoder #(
    parameter int BLOCK_LEN = 16,
    parameter int ALPHA     = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               key_i,
    enigma_stream_decoder_if.slave   bus
);

    localparam int IW = $clog2(BLOCK_LEN);
    localparam int RW = $clog2(ALPHA);
    localparam logic [IW-1:0] LAST_IDX  = IW'(BLOCK_LEN - 1);
    localparam logic [RW-1:0] ROT_MAX   = RW'(ALPHA - 1);
    localparam logic [5:0]    ALPHA6    = 6'(ALPHA);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          rdy_q;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [IW-1:0] last_idx_q, last_idx_d;
    logic [RW-1:0] rot_q, rot_d;
    logic [7:0]    mem_q [BLOCK_LEN];

    logic          in_ready;
    logic          accept;
    logic          wr_en;
    logic [RW-1:0] key_mod;
    logic [RW-1:0] sh;
    logic [RW-1:0] sh_next;
    logic          is_letter;
    logic [5:0]    ltr_idx;
    logic [5:0]    ltr_sum;
    logic [5:0]    ltr_red;
    logic [7:0]    plain;

    // rdy_q keeps in_ready low until the first clock after reset is released.
    assign in_ready     = rdy_q && (state_q == S_FILL);
    assign accept       = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;

    // Rotor position for the byte being accepted. Byte 0 of a block uses the
    // live key; every later byte uses the position stepped from the previous one.
    always_comb begin
        key_mod = RW'(key_i % 8'(ALPHA));
        sh      = (wr_idx_q == '0) ? key_mod : rot_q;
        sh_next = (sh == ROT_MAX) ? '0 : sh + 1'b1;
    end

    // Inverse Caesar on capital letters. All other bytes pass through unchanged.
    always_comb begin
        is_letter = (bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A);
        ltr_idx   = 6'(bus.in_data - 8'h41);
        ltr_sum   = ltr_idx + ALPHA6 - 6'(sh);
        ltr_red   = (ltr_sum >= ALPHA6) ? (ltr_sum - ALPHA6) : ltr_sum;
        plain     = is_letter ? (8'h41 + {2'b00, ltr_red}) : bus.in_data;
    end

    // Next-state, index and rotor update.
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        last_idx_d = last_idx_q;
        rot_d      = rot_q;
        wr_en      = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    rot_d = sh_next;
                    if (bus.in_last || (wr_idx_q == LAST_IDX)) begin
                        last_idx_d = wr_idx_q;
                        wr_idx_d   = '0;
                        rd_idx_d   = '0;
                        state_d    = S_DRAIN;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    if (rd_idx_q == last_idx_q) begin
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                        state_d  = S_FILL;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Control registers. An asynchronous reset drops any partial or pending block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            rdy_q      <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            last_idx_q <= '0;
            rot_q      <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= 1'b1;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            last_idx_q <= last_idx_d;
            rot_q      <= rot_d;
        end
    end

    // Block buffer. It has no reset because its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx_q] <= plain;
        end
    end

    // Output stream. It is driven straight from registered state, so it holds
    // steady while the consumer stalls.
    always_comb begin
        bus.out_valid = (state_q == S_DRAIN);
        bus.out_data  = (state_q == S_DRAIN) ? mem_q[rd_idx_q] : 8'h00;
        bus.out_last  = (state_q == S_DRAIN) && (rd_idx_q == last_idx_q);
    end

endmodule

// File: tb/tb_enigma_stream_decoder.sv
module tb_enigma_stream_decoder;

    typedef logic [7:0] q8_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key = 8'h00;

    enigma_stream_decoder_if bus ();

    enigma_stream_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key_i (key),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0: ready=1, 1: toggle, 2: random, 3: ready=0

    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic [7:0] got_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic q8_t to_q(input string s);
        q8_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference decryption: shift for byte i is (key mod 26 + i) mod 26, applied only to 'A'..'Z'.
    function automatic q8_t decode(input q8_t d, input logic [7:0] k);
        q8_t r;
        int  rot;
        int  c;
        int  sh;
        rot = int'(k) % 26;
        for (int i = 0; i < d.size(); i++) begin
            c  = int'(d[i]);
            sh = (rot + i) % 26;
            if (c >= 65 && c <= 90) c = 65 + ((c - 65 - sh + 26) % 26);
            r.push_back(8'(c));
        end
        return r;
    endfunction

    task automatic check_got(input string name, input string lit);
        string act;
        bit    ok;
        act = "";
        ok  = (got_q.size() == lit.len());
        for (int i = 0; i < got_q.size(); i++) begin
            act = $sformatf("%s%c", act, got_q[i]);
            if (i < lit.len() && got_q[i] != lit[i]) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=\"%s\" required=\"%s\"", name, act, lit);
        end
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Sends one block. If n_abort is nonzero, it stops after that many bytes and queues no expectation.
    task automatic send_block(input q8_t d, input logic [7:0] k, input bit use_last,
                              input bit key_chg, input int n_abort, input int gap_max);
        int  n;
        int  g;
        q8_t e;
        n   = (n_abort > 0) ? n_abort : d.size();
        key = k;
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(0, gap_max);
            repeat (g) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'($urandom);
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = d[i];
            bus.in_last  = use_last && (i == d.size() - 1);
            wait_accept();
            if (i == 0 && key_chg) key = 8'h03;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (n_abort == 0) begin
            e = decode(d, k);
            for (int j = 0; j < e.size(); j++) begin
                exp_d.push_back(e[j]);
                exp_l.push_back(j == e.size() - 1);
            end
            @(negedge clk);
            chk("latency_out_valid", 32'(bus.out_valid), 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_d.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_left required=0", exp_d.size());
        end
        #1;
        chk("in_ready_after_drain", 32'(bus.in_ready), 1);
        chk("out_valid_after_drain", 32'(bus.out_valid), 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_before_first_clk", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_first_clk", 32'(bus.in_ready), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", 32'(bus.out_valid), 0);
        chk("rst_async_in_ready", 32'(bus.in_ready), 0);
        exp_d.delete();
        exp_l.delete();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        release_reset();
    endtask

    // Consumer ready pattern, which changes just after each rising edge.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output checker, which samples on the falling edge.
    initial begin
        logic       pstall;
        logic [7:0] pd;
        logic       pl;
        pstall = 1'b0;
        pd     = 8'h00;
        pl     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", 32'(bus.out_valid), 0);
                chk("rst_out_data", 32'(bus.out_data), 0);
                chk("rst_out_last", 32'(bus.out_last), 0);
                pstall = 1'b0;
            end else begin
                if (bus.out_valid) begin
                    chk("in_ready_in_drain", 32'(bus.in_ready), 0);
                    if (pstall) begin
                        chk("stall_data", 32'(bus.out_data), 32'(pd));
                        chk("stall_last", 32'(bus.out_last), 32'(pl));
                    end
                    if (bus.out_ready) begin
                        if (exp_d.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output actual=%0h required=none", bus.out_data);
                        end else begin
                            chk("out_data", 32'(bus.out_data), 32'(exp_d.pop_front()));
                            chk("out_last", 32'(bus.out_last), 32'(exp_l.pop_front()));
                        end
                        got_q.push_back(bus.out_data);
                    end
                end
                pstall = bus.out_valid && !bus.out_ready;
                pd     = bus.out_data;
                pl     = bus.out_last;
            end
        end
    end

    // Main stimulus.
    initial begin
        q8_t rq;
        int  len;
        int  sel;
        bit  ul;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 0);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        release_reset();

        // Full 16-byte block with back-to-back bytes.
        mode = 0;
        got_q.delete();
        send_block(to_q("RHPHMIBNXNGIDUBW"), 8'h0F, 1'b0, 1'b0, 0, 0);
        wait_drain();
        check_got("case1_plaintext", "CRYPTOGRAPHICSYS");

        // Short block containing non-letters.
        got_q.delete();
        send_block(to_q("AZ{a"), 8'h00, 1'b1, 1'b0, 0, 0);
        wait_drain();
        check_got("case2_plaintext", "AY{a");

        // Single-byte block where the shift wraps.
        got_q.delete();
        send_block(to_q("A"), 8'hFF, 1'b1, 1'b0, 0, 0);
        wait_drain();
        check_got("case3_plaintext", "F");

        // Consumer stalls on alternate cycles.
        mode = 1;
        got_q.delete();
        send_block(to_q("RHPHMIBNXNGIDUBW"), 8'h0F, 1'b0, 1'b0, 0, 2);
        wait_drain();
        check_got("case4_backpressure", "CRYPTOGRAPHICSYS");

        // Key changes after the first byte of a block.
        mode = 0;
        got_q.delete();
        send_block(to_q("RHPHMIBNXNGIDUBW"), 8'h0F, 1'b0, 1'b1, 0, 1);
        wait_drain();
        check_got("case5_key_change", "CRYPTOGRAPHICSYS");

        // Reset after 7 bytes have been accepted.
        send_block(to_q("RHPHMIBNXNGIDUBW"), 8'h0F, 1'b0, 1'b0, 7, 0);
        do_reset();
        got_q.delete();
        send_block(to_q("RHPHMIBNXNGIDUBW"), 8'h0F, 1'b0, 1'b0, 0, 0);
        wait_drain();
        check_got("case6_reset_fill", "CRYPTOGRAPHICSYS");

        // Reset while the block is draining under a stalled consumer.
        mode = 3;
        send_block(to_q("RHPHMIBNXNGIDUBW"), 8'h21, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        do_reset();
        mode = 0;
        got_q.delete();
        send_block(to_q("RHPHMIBNXNGIDUBW"), 8'h0F, 1'b0, 1'b0, 0, 0);
        wait_drain();
        check_got("case6_reset_drain", "CRYPTOGRAPHICSYS");

        // Random blocks.
        for (int b = 0; b < 40; b++) begin
            rq.delete();
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                sel = $urandom_range(0, 3);
                if (sel < 3) rq.push_back(8'(8'h41 + $urandom_range(0, 25)));
                else         rq.push_back(8'($urandom));
            end
            ul   = (len < 16) ? 1'b1 : 1'($urandom);
            mode = $urandom_range(0, 2);
            send_block(rq, 8'($urandom), ul, 1'($urandom), 0, 3);
            wait_drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
